matmul_sched: RTL and testbench

MATMUL_SCHED -- requirements
Module: matmul_sched

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_mac.sv | 37 +++
 rtl/matmul_sched.sv | 154 +++++++++++++++
 tb/tb_matmul_sched.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply scheduler: state encoding,
// default widths, step count and the element-index packing helper.
package matmul_pkg;

  localparam int DW_DEF    = 8;
  localparam int RW_DEF    = 16;
  localparam int NUM_STEPS = 8;
  localparam int NUM_ELEM  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Element [i][j] of a packed 2x2 matrix lives at slot 2i+j.
  function automatic logic [1:0] elem_idx(input logic i, input logic j);
    return {i, j};
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed DW x DW multiplier feeding an RW-bit wrapping accumulator.
// acc_nxt is the value the accumulator takes on this edge when en is high.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [RW-1:0] acc_nxt
);

  logic signed [2*DW-1:0] prod;
  logic signed [RW-1:0]   acc_q;
  logic signed [RW-1:0]   acc_d;

  always_comb begin
    prod    = a * b;
    // Full-width signed product, then modulo-2^RW accumulate (no saturation).
    acc_nxt = (clr ? '0 : acc_q) + RW'(prod);
    acc_d   = en ? acc_nxt : acc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// Two-requester 2x2 signed matrix-multiply scheduler: round-robin arbitration,
// operand capture on grant, 8 serial MAC steps, one-cycle done to the owner.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [4*DW-1:0] a0,
  input  logic [4*DW-1:0] b0,
  input  logic [4*DW-1:0] a1,
  input  logic [4*DW-1:0] b1,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [4*RW-1:0] c,
  output logic            busy,
  output logic            owner
);

  state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [4*RW-1:0] c_q, c_d;

  logic signed [DW-1:0] a_q [NUM_ELEM];
  logic signed [DW-1:0] a_d [NUM_ELEM];
  logic signed [DW-1:0] b_q [NUM_ELEM];
  logic signed [DW-1:0] b_d [NUM_ELEM];
  logic signed [RW-1:0] res_q [NUM_ELEM];
  logic signed [RW-1:0] res_d [NUM_ELEM];

  logic                 win;
  logic                 mac_en;
  logic                 mac_clr;
  logic signed [DW-1:0] mac_a;
  logic signed [DW-1:0] mac_b;
  logic signed [RW-1:0] acc_nxt;

  // Step k walks element e = k[2:1] (i = k[2], j = k[1]) and term t = k[0].
  always_comb begin
    mac_a   = a_q[elem_idx(step_q[2], step_q[0])];
    mac_b   = b_q[elem_idx(step_q[0], step_q[1])];
    mac_clr = ~step_q[0];
    mac_en  = (state_q == ST_MAC);
  end

  matmul_mac #(
    .DW (DW),
    .RW (RW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en      (mac_en),
    .clr     (mac_clr),
    .a       (mac_a),
    .b       (mac_b),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      c_q     <= '0;
      for (int e = 0; e < NUM_ELEM; e++) begin
        a_q[e]   <= '0;
        b_q[e]   <= '0;
        res_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      c_q     <= c_d;
      for (int e = 0; e < NUM_ELEM; e++) begin
        a_q[e]   <= a_d[e];
        b_q[e]   <= b_d[e];
        res_q[e] <= res_d[e];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    // Round-robin pointer only decides when both requesters contend.
    win     = (req == 2'b11) ? rr_q : req[1];

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_LOAD;
          owner_d = win;
          for (int e = 0; e < NUM_ELEM; e++) begin
            a_d[e] = win ? a1[e*DW +: DW] : a0[e*DW +: DW];
            b_d[e] = win ? b1[e*DW +: DW] : b0[e*DW +: DW];
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_MAC;
        step_d  = '0;
      end
      ST_MAC: begin
        step_d = step_q + 3'd1;
        if (step_q[0]) begin
          res_d[step_q[2:1]] = acc_nxt;
        end
        if (step_q == 3'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
          // The visible result only changes as a whole, at completion.
          for (int e = 0; e < NUM_ELEM; e++) begin
            c_d[e*RW +: RW] = res_d[e];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rr_d    = ~owner_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt   = 2'b00;
    done  = 2'b00;
    busy  = (state_q != ST_IDLE);
    owner = owner_q;
    c     = c_q;
    if (state_q == ST_LOAD) begin
      gnt[owner_q] = 1'b1;
    end
    if (state_q == ST_DONE) begin
      done[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched: single request, contention/alternation,
// signed wrap, operand hold after capture and reset in the middle of MAC.
module tb_matmul_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  gnt, done;
  logic [63:0] c;
  logic        busy, owner;

  int checks;
  int errors;
  int gw;

  matmul_sched #(.DW(8), .RW(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt   (gnt),
    .done  (done),
    .c     (c),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m8(input int x00, input int x01, input int x10, input int x11);
    return {8'(x11), 8'(x10), 8'(x01), 8'(x00)};
  endfunction

  function automatic logic [63:0] m16(input int x00, input int x01, input int x10, input int x11);
    return {16'(x11), 16'(x10), 16'(x01), 16'(x00)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks it, drops the served req bit, then waits for done.
  task automatic serve(input string tag, input logic [1:0] exp_g, input logic [63:0] exp_c,
                       input bit mod_a0, output int gwait);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 40);
    gwait = n;
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
    check({tag, "_owner"}, 64'(owner), 64'(exp_g[1]));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    req = req & ~gnt;
    if (mod_a0) a0 = {4{8'd7}};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 2'b00 && n < 40);
    check({tag, "_latency"}, 64'(n), 64'd9);
    check({tag, "_done"}, 64'(done), 64'(exp_g));
    check({tag, "_gnt_at_done"}, 64'(gnt), 64'd0);
    check({tag, "_c"}, c, exp_c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    req = 2'b00;
    a0 = m8(1, 2, 3, 4);
    b0 = m8(5, 6, 7, 8);
    a1 = m8(1, 0, 0, 1);
    b1 = m8(2, 3, 4, 5);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_c", c, 64'd0);
    rst = 1'b1;

    // Single request from requester 0.
    req = 2'b01;
    serve("single", 2'b01, m16(19, 22, 43, 50), 1'b0, gw);
    check("single_gwait", 64'(gw), 64'd1);
    @(negedge clk);
    check("single_idle_busy", 64'(busy), 64'd0);
    check("single_c_held", c, m16(19, 22, 43, 50));

    // Operand change after capture must not disturb the result.
    req = 2'b01;
    serve("hold", 2'b01, m16(19, 22, 43, 50), 1'b1, gw);
    a0 = m8(1, 2, 3, 4);

    // Contention from a fresh reset: requester 0 first, then alternation.
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    serve("cont0", 2'b01, m16(19, 22, 43, 50), 1'b0, gw);
    check("cont0_gwait", 64'(gw), 64'd1);
    serve("cont1", 2'b10, m16(2, 3, 4, 5), 1'b0, gw);
    check("cont1_gwait", 64'(gw), 64'd2);
    req = 2'b11;
    serve("cont2", 2'b01, m16(19, 22, 43, 50), 1'b0, gw);
    check("cont2_gwait", 64'(gw), 64'd2);
    serve("cont3", 2'b10, m16(2, 3, 4, 5), 1'b0, gw);
    check("cont3_owner_held", 64'(owner), 64'd1);

    // Signed operands; element [0][0] wraps from +32768.
    a0 = m8(-128, -128, 0, 1);
    b0 = m8(-128, 0, -128, -1);
    req = 2'b01;
    serve("wrap", 2'b01, m16(-32768, 128, -128, -1), 1'b0, gw);

    // Reset at MAC step 4, request left asserted.
    a0 = m8(1, 2, 3, 4);
    b0 = m8(5, 6, 7, 8);
    req = 2'b01;
    gw = 0;
    do begin
      @(negedge clk);
      gw++;
    end while (gnt == 2'b00 && gw < 40);
    check("abort_gnt", 64'(gnt), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_c", c, 64'd0);
    check("abort_owner", 64'(owner), 64'd0);
    check("abort_gnt0", 64'(gnt), 64'd0);
    check("abort_done0", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_done_held", 64'(done), 64'd0);
    rst = 1'b1;
    serve("resume", 2'b01, m16(19, 22, 43, 50), 1'b0, gw);
    check("resume_gwait", 64'(gw), 64'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
